// File: rtl/scoreboard_fwd_unit_pkg.sv
// Shared types and constants for the issue scoreboard / forwarding unit.
// Optional forwarding build: SCOREBOARD_FORWARDING_EN.
package scoreboard_pkg;

  function automatic int sb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Slot rd field is wide enough for up to 256 registers.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_slot_t;

  localparam logic [SB_RD_W-1:0] SB_REG_ZERO   = '0;
  localparam logic [31:0]        STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/scoreboard_fwd_unit_if.sv
// ID-side bundle between decoder, scoreboard and ID/EX register.
// master = decode side, slave = scoreboard.
interface scoreboard_fwd_unit_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2
);
  import scoreboard_pkg::*;

  localparam int AW = sb_clog2(NREG);

  logic                    issue_valid;
  logic                    issue_rf_wen;
  logic                    issue_is_load;
  logic [AW-1:0]           issue_rd;
  logic [NUM_SRC*AW-1:0]   src_addr;
  logic [NUM_SRC-1:0]      src_used;
  logic                    flush;
  logic [DEPTH*XLEN-1:0]   stage_data;
  logic                    stall;
  logic [NUM_SRC-1:0]      fwd_hit;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic [31:0]             stall_count;

  modport master (
    output issue_valid, issue_rf_wen,
    output issue_is_load, issue_rd,
    output src_addr, src_used,
    output flush, stage_data,
    input  stall, fwd_hit,
    input  fwd_data, stall_count
  );

  modport slave (
    input  issue_valid, issue_rf_wen,
    input  issue_is_load, issue_rd,
    input  src_addr, src_used,
    input  flush, stage_data,
    output stall, fwd_hit,
    output fwd_data, stall_count
  );

endinterface

// File: rtl/scoreboard_fwd_unit_slot_pipe.sv
// DEPTH-entry shift register of in-flight writes.
// Slot 0 loads every cycle; the last slot retires.
module sb_slot_pipe
  import scoreboard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  sb_slot_t              load_i,
  output sb_slot_t [DEPTH-1:0]  slot_o
);

  sb_slot_t [DEPTH-1:0] slot_q;
  sb_slot_t [DEPTH-1:0] slot_d;

  always_comb begin
    slot_d    = slot_q;
    slot_d[0] = load_i;
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/scoreboard_fwd_unit.sv
// Issue scoreboard: stall / forward decisions for ID source operands.
// Define SCOREBOARD_FORWARDING_EN for bypassing; default is stall-only.
module scoreboard_fwd_unit
  import scoreboard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_READY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  scoreboard_fwd_unit_if.slave sb
);

  localparam int AW = sb_clog2(NREG);
  localparam int IW = sb_clog2(DEPTH);

  sb_slot_t [DEPTH-1:0] slot;
  sb_slot_t             slot0_in;
  logic                 accept;
  logic                 stall_w;

  logic [NUM_SRC-1:0][SB_RD_W-1:0] src_rd;
  logic [NUM_SRC-1:0]              m_any;
  logic [NUM_SRC-1:0]              m_load;
  logic [NUM_SRC-1:0][IW-1:0]      m_idx;
  logic [NUM_SRC-1:0][XLEN-1:0]    m_data;

  logic [NUM_SRC-1:0]      op_stall;
  logic [NUM_SRC-1:0]      hit;
  logic [NUM_SRC*XLEN-1:0] fdata;

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    src_rd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_rd[i] = SB_RD_W'(sb.src_addr[i*AW +: AW]);
    end
  end

  // Scan oldest to youngest so the lowest matching slot wins.
  always_comb begin
    m_any  = '0;
    m_load = '0;
    m_idx  = '0;
    m_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot[k].valid && sb.src_used[i] &&
            src_rd[i] == slot[k].rd &&
            src_rd[i] != SB_REG_ZERO) begin
          m_any[i]  = 1'b1;
          m_load[i] = slot[k].is_load;
          m_idx[i]  = IW'(k);
          m_data[i] = sb.stage_data[k*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef SCOREBOARD_FORWARDING_EN
  always_comb begin
    op_stall = '0;
    hit      = '0;
    fdata    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_any[i]) begin
        if (m_load[i] && (int'(m_idx[i]) < LOAD_READY)) begin
          op_stall[i] = 1'b1;
        end else begin
          hit[i] = 1'b1;
          fdata[i*XLEN +: XLEN] = m_data[i];
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{m_load, m_idx, m_data};

  always_comb begin
    op_stall = m_any;
    hit      = '0;
    fdata    = '0;
  end
`endif

  assign stall_w = |op_stall;
  assign accept  = sb.issue_valid & ~stall_w & ~sb.flush;

  always_comb begin
    slot0_in = '0;
    if (accept && sb.issue_rf_wen &&
        SB_RD_W'(sb.issue_rd) != SB_REG_ZERO) begin
      slot0_in.valid   = 1'b1;
      slot0_in.rd      = SB_RD_W'(sb.issue_rd);
      slot0_in.is_load = sb.issue_is_load;
    end
  end

  sb_slot_pipe #(
    .DEPTH (DEPTH)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .load_i (slot0_in),
    .slot_o (slot)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (stall_w && sb.issue_valid && !sb.flush &&
        cnt_q != STALL_CNT_MAX) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sb.stall       = stall_w;
  assign sb.fwd_hit     = hit;
  assign sb.fwd_data    = fdata;
  assign sb.stall_count = cnt_q;

endmodule
